mac_accumulator_bank: RTL and testbench
=======================================

MAC_ACCUMULATOR_BANK -- requirements
Module: mac_accumulator_bank

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 25: accumulator lane width, signed.
REQ-002 The block SHALL have parameter IN_WIDTH, default 16: per-lane product width, signed.
REQ-003 The block SHALL have parameter VEC_LENGTH, default 4: number of lanes.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 8: width of the accumulation-length counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous abort of the current accumulation.
REQ-008 The block SHALL have port cfg_len, input, CNT_WIDTH bits: products per lane in one accumulation; sampled at the first input handshake.
REQ-009 The block SHALL have port cfg_sel, input, 3 bits: reduction select code; sampled at the first input handshake.
REQ-010 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-011 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data.
REQ-012 The block SHALL have port in_data, input, signed IN_WIDTH x VEC_LENGTH (unpacked array): per-lane products.
REQ-013 The block SHALL have port out_valid, output, 1 bit: accum, sel and ovf hold a completed result.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the downstream reduction stage consumes the result.
REQ-015 The block SHALL have port accum, output, signed DATA_WIDTH x VEC_LENGTH (unpacked array): lane accumulators, registered.
REQ-016 The block SHALL have port sel, output, 3 bits: latched cfg_sel, registered, driving the downstream reduction mux.
REQ-017 The block SHALL have port ovf, output, VEC_LENGTH bits: per-lane sticky saturation flag for the current result.

Function
REQ-018 An input handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-019 The FSM SHALL have states IDLE, ACCUM and HOLD.
REQ-020 in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD, and 0 while rst_n=0.
REQ-021 out_valid SHALL be 1 exactly in HOLD.
REQ-022 The effective length L SHALL be cfg_len, except that cfg_len=0 SHALL be treated as L=1.
REQ-023 On a handshake in IDLE, the block SHALL:
- load each accum lane with sign-extended in_data (no add to the stale value);
- clear ovf;
- latch L and sel;
- set count=1;
- go to HOLD if L=1, else to ACCUM.
REQ-024 On a handshake in ACCUM, the block SHALL add sign-extended in_data to each lane and increment count; when the new count equals L it SHALL go to HOLD.
REQ-025 Each lane add SHALL saturate to the signed DATA_WIDTH limits, +(2^(DATA_WIDTH-1)-1) and -2^(DATA_WIDTH-1), and set that lane's ovf bit on saturation.
REQ-026 ACCUM cycles without a handshake SHALL leave accum, count and state unchanged.
REQ-027 out_valid SHALL rise on the cycle after the handshake that completes L products (latency 1).
REQ-028 In HOLD, accum, sel and ovf SHALL remain stable until out_ready=1; on that edge the FSM SHALL go to IDLE with accum held.
REQ-029 in_valid in HOLD SHALL be ignored, including in the same cycle as out_ready; the next input SHALL be accepted no earlier than the following cycle.
REQ-030 clear=1 SHALL have priority over all other events in every state:
- next state IDLE;
- accum lanes 0, ovf 0, count 0, sel 3'b000;
- out_valid drops on the next cycle;
- a concurrent input handshake is discarded.
REQ-031 cfg_len and cfg_sel changes after the first handshake SHALL NOT affect the accumulation in progress.

Reset
REQ-032 While rst_n=0, the block SHALL asynchronously force:
- state IDLE;
- every accum lane 0, sel 3'b000, ovf 0, count 0;
- out_valid 0 and in_ready 0.
REQ-033 Reset asserted mid-accumulation or in HOLD SHALL discard the partial result, with no output handshake afterward.
REQ-034 After rst_n deasserts, the first handshake SHALL be treated as the first of a new accumulation.

Verification
REQ-035 The bench SHALL cover basic accumulation:
- stimulus: cfg_len=3, cfg_sel=3'b100, in_data {1,2,3,4} for 3 consecutive cycles, out_ready=1;
- response: out_valid=1 for one cycle, 1 cycle after the 3rd handshake, with accum={3,6,9,12}, sel=3'b100, ovf=0.
REQ-036 The bench SHALL cover backpressure:
- stimulus: cfg_len=2, two inputs, out_ready=0 for 5 cycles;
- response: out_valid and accum stable for 5 cycles, in_ready=0 throughout, IDLE after out_ready=1.
REQ-037 The bench SHALL cover saturation:
- stimulus: DATA_WIDTH=17, IN_WIDTH=16, cfg_len=4, lane0 fed 32767 each cycle;
- response: accum[0]=65535, ovf[0]=1, other lanes' ovf=0.
REQ-038 The bench SHALL cover stall and length 0:
- stimulus: cfg_len=0, single input {-5,0,7,-1};
- response: HOLD next cycle with accum={-5,0,7,-1};
- stimulus: cfg_len=3 with in_valid gaps;
- response: the result still sums exactly 3 products.
REQ-039 The bench SHALL cover clear:
- stimulus: clear=1 during the 2nd of 4 inputs, concurrent with a handshake;
- response: accum all 0, IDLE; the next 4 inputs give a fresh sum with no residue.
REQ-040 The bench SHALL cover async reset:
- stimulus: rst_n pulsed low mid-cycle while in HOLD;
- response: out_valid=0 and accum=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mac_accumulator_bank_if.sv
// Bundle for the lane-product input stream, the accumulation configuration
// and the result handshake toward the downstream reduction stage.
interface mac_accumulator_bank_if #(
  parameter int DATA_WIDTH = 25,
  parameter int IN_WIDTH   = 16,
  parameter int VEC_LENGTH = 4,
  parameter int CNT_WIDTH  = 8
);
  logic                         clear;
  logic [CNT_WIDTH-1:0]         cfg_len;
  logic [2:0]                   cfg_sel;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [IN_WIDTH-1:0]   in_data [VEC_LENGTH];
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] accum [VEC_LENGTH];
  logic [2:0]                   sel;
  logic [VEC_LENGTH-1:0]        ovf;

  modport master (
    output clear, cfg_len, cfg_sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, accum, sel, ovf
  );

  modport slave (
    input  clear, cfg_len, cfg_sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, accum, sel, ovf
  );
endinterface

// File: rtl/mac_accumulator_bank.sv
// Bank of saturating signed lane accumulators. Each accumulation sums L
// per-lane products (L latched at the first accepted input), then holds the
// result with out_valid until the downstream stage takes it.
module mac_accumulator_bank #(
  parameter int DATA_WIDTH = 25,
  parameter int IN_WIDTH   = 16,
  parameter int VEC_LENGTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  mac_accumulator_bank_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic signed [DATA_WIDTH-1:0] ACC_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] ACC_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] accum_q [VEC_LENGTH];
  logic signed [DATA_WIDTH-1:0] sum_res [VEC_LENGTH];
  logic [VEC_LENGTH-1:0]        sat_res;
  logic [VEC_LENGTH-1:0]        ovf_q;
  logic [2:0]                   sel_q;
  logic [CNT_WIDTH-1:0]         cnt_q, len_q, len_eff, cnt_inc;
  logic                         hs;

  // Signed add with clamp to the lane range; MSB of the result flags a clamp.
  function automatic logic [DATA_WIDTH:0] sat_add(
    input logic signed [DATA_WIDTH-1:0] acc,
    input logic signed [IN_WIDTH-1:0]   x
  );
    logic signed [DATA_WIDTH:0] wide;
    wide = (DATA_WIDTH+1)'(acc) + (DATA_WIDTH+1)'(x);
    if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1])
      sat_add = wide[DATA_WIDTH] ? {1'b1, ACC_MIN} : {1'b1, ACC_MAX};
    else
      sat_add = {1'b0, wide[DATA_WIDTH-1:0]};
  endfunction

  // in_ready is gated by rst_n so nothing is offered while reset is held.
  assign bus.in_ready  = rst_n & (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign hs            = bus.in_valid & bus.in_ready;
  assign len_eff       = (bus.cfg_len == '0) ? CNT_WIDTH'(1) : bus.cfg_len;
  assign cnt_inc       = cnt_q + CNT_WIDTH'(1);
  assign bus.sel       = sel_q;
  assign bus.ovf       = ovf_q;

  for (genvar i = 0; i < VEC_LENGTH; i++) begin : g_lane
    assign {sat_res[i], sum_res[i]} = sat_add(accum_q[i], bus.in_data[i]);
    assign bus.accum[i]             = accum_q[i];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: clear wins; HOLD ignores inputs until the result is taken.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (hs) state_d = (len_eff == CNT_WIDTH'(1)) ? HOLD : ACCUM;
        ACCUM:   if (hs && (cnt_inc == len_q)) state_d = HOLD;
        HOLD:    if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Lane accumulators, flags and latched configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VEC_LENGTH; i++) accum_q[i] <= '0;
      ovf_q <= '0;
      sel_q <= 3'b000;
      cnt_q <= '0;
      len_q <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < VEC_LENGTH; i++) accum_q[i] <= '0;
      ovf_q <= '0;
      sel_q <= 3'b000;
      cnt_q <= '0;
      len_q <= '0;
    end else if (hs && state_q == IDLE) begin
      // First product replaces whatever the previous result left behind.
      for (int i = 0; i < VEC_LENGTH; i++) accum_q[i] <= DATA_WIDTH'(bus.in_data[i]);
      ovf_q <= '0;
      sel_q <= bus.cfg_sel;
      len_q <= len_eff;
      cnt_q <= CNT_WIDTH'(1);
    end else if (hs && state_q == ACCUM) begin
      for (int i = 0; i < VEC_LENGTH; i++) accum_q[i] <= sum_res[i];
      ovf_q <= ovf_q | sat_res;
      cnt_q <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_mac_accumulator_bank.sv
// Randomized and directed bench for mac_accumulator_bank with an
// integer-arithmetic reference model of the accumulation rules.
module tb_mac_accumulator_bank;

  localparam int DW = 17;
  localparam int IW = 16;
  localparam int VL = 4;
  localparam int CW = 8;
  localparam int AMAX = (1 << (DW-1)) - 1;
  localparam int AMIN = -(1 << (DW-1));

  logic clk;
  logic rst_n;

  mac_accumulator_bank_if #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .VEC_LENGTH(VL), .CNT_WIDTH(CW)) bus ();

  mac_accumulator_bank #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .VEC_LENGTH(VL), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int m_acc [VL];
  bit m_ovf [VL];
  int m_sel, m_len, m_n;
  bit m_active, m_hold;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < VL; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
    m_sel = 0; m_len = 0; m_n = 0; m_active = 0; m_hold = 0;
  endtask

  // One clock edge of the accumulation rules, from the inputs now applied.
  task automatic model_edge();
    int s;
    if (bus.clear) begin
      model_reset();
    end else if (m_hold) begin
      if (bus.out_ready) m_hold = 0;
    end else if (bus.in_valid) begin
      if (!m_active) begin
        m_len = (bus.cfg_len == 0) ? 1 : int'(bus.cfg_len);
        m_sel = int'(bus.cfg_sel);
        m_n   = 0;
        for (int i = 0; i < VL; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
      end
      for (int i = 0; i < VL; i++) begin
        s = m_acc[i] + int'(bus.in_data[i]);
        if (s > AMAX) begin s = AMAX; m_ovf[i] = 1; end
        if (s < AMIN) begin s = AMIN; m_ovf[i] = 1; end
        m_acc[i] = s;
      end
      m_n++;
      if (m_n == m_len) begin m_hold = 1; m_active = 0; end
      else m_active = 1;
    end
  endtask

  task automatic compare_all(input string ph);
    logic [VL-1:0] ev;
    for (int i = 0; i < VL; i++) ev[i] = m_ovf[i];
    chk({ph, ".in_ready"}, bus.in_ready, (rst_n && !m_hold) ? 1 : 0);
    chk({ph, ".out_valid"}, bus.out_valid, m_hold ? 1 : 0);
    for (int i = 0; i < VL; i++) chk($sformatf("%s.accum%0d", ph, i), bus.accum[i], m_acc[i]);
    chk({ph, ".sel"}, bus.sel, m_sel);
    chk({ph, ".ovf"}, bus.ovf, ev);
  endtask

  task automatic tick(input string ph);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(ph);
  endtask

  task automatic set_in(input bit v, input int a, input int b, input int c, input int d);
    bus.in_valid   = v;
    bus.in_data[0] = IW'(a);
    bus.in_data[1] = IW'(b);
    bus.in_data[2] = IW'(c);
    bus.in_data[3] = IW'(d);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.cfg_len   = '0;
    bus.cfg_sel   = 3'b000;
    bus.out_ready = 1'b0;
    set_in(0, 0, 0, 0, 0);
    model_reset();

    // reset state
    #3;
    chk("rst.in_ready", bus.in_ready, 0);
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.accum0", bus.accum[0], 0);
    chk("rst.sel", bus.sel, 0);
    chk("rst.ovf", bus.ovf, 0);
    #19 rst_n = 1'b1;

    // basic: three products, result pulses for one cycle
    bus.cfg_len = 8'd3; bus.cfg_sel = 3'b100; bus.out_ready = 1'b1;
    set_in(1, 1, 2, 3, 4);
    tick("basic"); tick("basic");
    chk("basic.mid_valid", bus.out_valid, 0);
    tick("basic");
    set_in(0, 0, 0, 0, 0);
    chk("basic.valid", bus.out_valid, 1);
    chk("basic.a0", bus.accum[0], 3);
    chk("basic.a1", bus.accum[1], 6);
    chk("basic.a2", bus.accum[2], 9);
    chk("basic.a3", bus.accum[3], 12);
    chk("basic.sel", bus.sel, 3'b100);
    chk("basic.ovf", bus.ovf, 0);
    tick("basic");
    chk("basic.pulse_end", bus.out_valid, 0);

    // backpressure: result held while out_ready is low, inputs ignored
    bus.cfg_len = 8'd2; bus.out_ready = 1'b0;
    set_in(1, 10, -20, 30, -40);
    tick("bp"); tick("bp");
    for (int k = 0; k < 5; k++) begin
      tick("bp");
      chk("bp.valid", bus.out_valid, 1);
      chk("bp.ready", bus.in_ready, 0);
      chk("bp.a0", bus.accum[0], 20);
      chk("bp.a3", bus.accum[3], -80);
    end
    bus.out_ready = 1'b1;
    tick("bp");
    chk("bp.released", bus.out_valid, 0);
    chk("bp.idle_ready", bus.in_ready, 1);
    set_in(0, 0, 0, 0, 0);
    tick("bp");

    // saturation on lane 0
    bus.cfg_len = 8'd4;
    set_in(1, 32767, 1, -1, 2);
    repeat (4) tick("sat");
    set_in(0, 0, 0, 0, 0);
    chk("sat.a0", bus.accum[0], 65535);
    chk("sat.ovf", bus.ovf, 4'b0001);
    chk("sat.a3", bus.accum[3], 8);
    tick("sat");

    // length 0 acts as length 1
    bus.cfg_len = 8'd0;
    set_in(1, -5, 0, 7, -1);
    tick("len0");
    set_in(0, 0, 0, 0, 0);
    chk("len0.valid", bus.out_valid, 1);
    chk("len0.a0", bus.accum[0], -5);
    chk("len0.a2", bus.accum[2], 7);
    chk("len0.a3", bus.accum[3], -1);
    tick("len0");

    // stalls between products; cfg changes mid-run must not matter
    bus.cfg_len = 8'd3; bus.cfg_sel = 3'b011;
    set_in(1, 5, -1, 0, 0); tick("stall");
    bus.cfg_len = 8'd1; bus.cfg_sel = 3'b111;
    set_in(0, 99, 99, 99, 99); tick("stall");
    set_in(1, 6, -1, 0, 0); tick("stall");
    set_in(0, 99, 99, 99, 99); tick("stall"); tick("stall");
    set_in(1, 7, -1, 0, 0); tick("stall");
    set_in(0, 0, 0, 0, 0);
    chk("stall.valid", bus.out_valid, 1);
    chk("stall.a0", bus.accum[0], 18);
    chk("stall.a1", bus.accum[1], -3);
    chk("stall.sel", bus.sel, 3'b011);
    tick("stall");

    // clear concurrent with the second handshake
    bus.cfg_len = 8'd4;
    set_in(1, 100, 200, 300, 400); tick("clr");
    bus.clear = 1'b1;
    set_in(1, 50, 50, 50, 50); tick("clr");
    bus.clear = 1'b0;
    chk("clr.a0", bus.accum[0], 0);
    chk("clr.a3", bus.accum[3], 0);
    chk("clr.idle", bus.in_ready, 1);
    set_in(1, 1, 2, 3, 4);
    repeat (4) tick("clr");
    set_in(0, 0, 0, 0, 0);
    chk("clr.valid", bus.out_valid, 1);
    chk("clr.a0", bus.accum[0], 4);
    chk("clr.a3", bus.accum[3], 16);
    tick("clr");

    // async reset mid-cycle while holding a result
    bus.cfg_len = 8'd1; bus.out_ready = 1'b0;
    set_in(1, 9, 9, 9, 9); tick("arst");
    set_in(0, 0, 0, 0, 0);
    chk("arst.hold", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", bus.out_valid, 0);
    chk("arst.a0", bus.accum[0], 0);
    chk("arst.ready", bus.in_ready, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick("arst"); tick("arst");
    bus.cfg_len = 8'd2;
    set_in(1, -3, 4, -5, 6); tick("arst"); tick("arst");
    set_in(0, 0, 0, 0, 0);
    chk("arst.new_a0", bus.accum[0], -6);
    tick("arst");

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      bus.clear     = ($urandom_range(0, 99) < 3);
      bus.out_ready = ($urandom_range(0, 1) == 1);
      bus.cfg_len   = CW'($urandom_range(0, 5));
      bus.cfg_sel   = 3'($urandom);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < VL; i++) begin
        if ($urandom_range(0, 3) == 0) bus.in_data[i] = IW'($urandom);
        else bus.in_data[i] = IW'(int'($urandom_range(0, 200)) - 100);
      end
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
